ring_counter_core: RTL and testbench

Parameterised one-hot ring counter: a single set bit circulates around a WIDTH-bit register, one position per enabled clock. It serves as a sequencer or phase generator for round-robin selects, strobe generation and time-slot enables. Direction control, parallel load, a wrap strobe and a one-hot integrity flag are provided. The RTL module is named `ring_counter_core`.

---
 rtl/ring_counter_core.sv | 87 ++++++++
 tb/tb_ring_counter_core.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ring_counter_core.sv
// ring_counter_core: one-hot ring counter with a single circulating bit.
// Features: left/right rotation, a synchronous parallel load that takes priority over
// advance, a registered wrap strobe, and a combinational one-hot integrity flag.
// Optional feature macro RING_COUNTER_SELFCORRECT_EN: illegal states and illegal
// loads are replaced by INIT, so the ring recovers from upsets.
module ring_counter_core #(
   parameter int unsigned    WIDTH = 4,
   parameter logic [WIDTH-1:0] INIT  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             wrap,
   output logic             onehot_err
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic             q_legal;
   logic             load_legal;

   // A value is one-hot when it is non-zero and clearing its lowest set bit leaves zero.
   function automatic logic is_onehot(input logic [WIDTH-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   // Integrity of the current ring state and of the value offered for loading.
   always_comb begin
      q_legal    = is_onehot(q_q);
      load_legal = is_onehot(load_val);
   end

   // Next-state selection: load beats advance, advance beats hold.
   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (load) begin
`ifdef RING_COUNTER_SELFCORRECT_EN
         q_d = load_legal ? load_val : INIT;
`else
         q_d = load_val;
`endif
`ifdef RING_COUNTER_SELFCORRECT_EN
      end else if (!q_legal) begin
         // Recover to the start position instead of rotating a corrupted pattern.
         q_d = INIT;
`endif
      end else if (en) begin
         if (dir) begin
            q_d    = {q_q[0], q_q[WIDTH-1:1]};
            wrap_d = q_q[0];
         end else begin
            q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            wrap_d = q_q[WIDTH-1];
         end
      end
   end

   // Ring and strobe registers; reset returns to the start position immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q    <= INIT;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   // Outputs: registered state and strobe, combinational integrity flag.
   always_comb begin
      q          = q_q;
      wrap       = wrap_q;
      onehot_err = !q_legal;
   end

`ifndef RING_COUNTER_SELFCORRECT_EN
   // load_legal only matters when self-correction is compiled in.
   logic unused_load_legal;
   always_comb unused_load_legal = load_legal;
`endif

endmodule

// File: tb/tb_ring_counter_core.sv
// Directed bench for ring_counter_core (WIDTH=4, INIT=0001).
// Expectations follow the build: RING_COUNTER_SELFCORRECT_EN selects the recovering variant.
module tb_ring_counter_core;

   logic       clk;
   logic       rst;
   logic       en;
   logic       dir;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] q;
   logic       wrap;
   logic       onehot_err;

   int n_checks = 0;
   int n_fail   = 0;
   int wraps;

   ring_counter_core #(
      .WIDTH(4),
      .INIT (4'b0001)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .dir       (dir),
      .load      (load),
      .load_val  (load_val),
      .q         (q),
      .wrap      (wrap),
      .onehot_err(onehot_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one edge and sample 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [3:0] eq, input logic ew,
                              input logic ee);
      check_eq({tag, ".q"}, 64'(q), 64'(eq));
      check_eq({tag, ".wrap"}, 64'(wrap), 64'(ew));
      check_eq({tag, ".err"}, 64'(onehot_err), 64'(ee));
   endtask

   initial begin
      rst      = 1'b0;
      en       = 1'b1;
      dir      = 1'b0;
      load     = 1'b0;
      load_val = 4'b0000;
      #100;
      check_state("reset", 4'b0001, 1'b0, 1'b0);

      // Release between edges, then rotate left through a full period.
      @(posedge clk);
      #1 rst = 1'b1;
      step(); check_state("left1", 4'b0010, 1'b0, 1'b0);
      step(); check_state("left2", 4'b0100, 1'b0, 1'b0);
      step(); check_state("left3", 4'b1000, 1'b0, 1'b0);
      step(); check_state("left4", 4'b0001, 1'b1, 1'b0);
      step(); check_state("left5", 4'b0010, 1'b0, 1'b0);

      // Load start position, then rotate right.
      load = 1'b1; load_val = 4'b0001;
      step(); check_state("ld0001", 4'b0001, 1'b0, 1'b0);
      load = 1'b0; dir = 1'b1;
      step(); check_state("right1", 4'b1000, 1'b1, 1'b0);
      step(); check_state("right2", 4'b0100, 1'b0, 1'b0);
      step(); check_state("right3", 4'b0010, 1'b0, 1'b0);

      // Hold with en low.
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(); check_state("hold", 4'b0010, 1'b0, 1'b0);
      end

      // Load wins over en on the same edge.
      en = 1'b1; load = 1'b1; load_val = 4'b0100;
      step(); check_state("ld_pri", 4'b0100, 1'b0, 1'b0);

      // Async reset mid-cycle with a load pending.
      load_val = 4'b1000; dir = 1'b0;
      #2 rst = 1'b0;
      #1 check_state("async_rst", 4'b0001, 1'b0, 1'b0);
      step(); check_state("rst_held", 4'b0001, 1'b0, 1'b0);
      rst = 1'b1; load = 1'b0;
      step(); check_state("post_rst", 4'b0010, 1'b0, 1'b0);

      // Illegal load 0110.
      load = 1'b1; load_val = 4'b0110;
      step();
`ifdef RING_COUNTER_SELFCORRECT_EN
      check_state("ill_ld", 4'b0001, 1'b0, 1'b0);
      load = 1'b0;
      step(); check_state("ill_rot", 4'b0010, 1'b0, 1'b0);
`else
      check_state("ill_ld", 4'b0110, 1'b0, 1'b1);
      load = 1'b0;
      step(); check_state("ill_rot1", 4'b1100, 1'b0, 1'b1);
      step(); check_state("ill_rot2", 4'b1001, 1'b1, 1'b1);
`endif

      // Zero load.
      load = 1'b1; load_val = 4'b0000;
      step();
`ifdef RING_COUNTER_SELFCORRECT_EN
      check_state("zero_ld", 4'b0001, 1'b0, 1'b0);
      load = 1'b0;
`else
      check_state("zero_ld", 4'b0000, 1'b0, 1'b1);
      load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(); check_state("zero_hold", 4'b0000, 1'b0, 1'b1);
      end
`endif

      // Two full left periods from the start position: exactly two wrap pulses.
      load = 1'b1; load_val = 4'b0001;
      step();
      load = 1'b0; wraps = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (wrap) wraps++;
      end
      check_eq("wrap_count", 64'(wraps), 64'd2);
      check_eq("period_q", 64'(q), 64'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
